// File: rtl/cocoa_mux_pkg.sv
// Shared mux definitions: mode encodings and the select-width helper.
package cocoa_mux_pkg;

   localparam int MUX_MODE_SEL = 0;
   localparam int MUX_MODE_RR  = 1;

   // Width of a channel index; never below one bit.
   function automatic int sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin grant over req, searching upward from ptr with wrap; combinational grant.
// ptr moves past the granted channel only when advance (an input transfer) is high.
module rr_arbiter
   import cocoa_mux_pkg::*;
#(
   parameter int NUM_IN = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_IN-1:0]                req,
   input  logic                             advance,
   output logic [NUM_IN-1:0]                grant,
   output logic [sel_width(NUM_IN)-1:0]     grant_idx
);

   localparam int SW = sel_width(NUM_IN);

   logic [SW-1:0] ptr;
   logic          found;
   int            idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int i = 0; i < NUM_IN; i++) begin
         idx = (int'(ptr) + i) % NUM_IN;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = SW'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (grant_idx == SW'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/stream_mux.sv
// N:1 stream mux (sel-indexed or round-robin) into a single output register; 1-cycle latency.
// Accepts a new word only when the register is empty or being drained; full throughput.
module stream_mux
   import cocoa_mux_pkg::*;
#(
   parameter int WIDTH_DATA = 32,
   parameter int NUM_IN     = 4,
   parameter int MODE       = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_IN*WIDTH_DATA-1:0]     in_data,
   input  logic [NUM_IN-1:0]                in_valid,
   output logic [NUM_IN-1:0]                in_ready,
   input  logic [sel_width(NUM_IN)-1:0]     sel,
   output logic [WIDTH_DATA-1:0]            out_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [sel_width(NUM_IN)-1:0]     out_src
);

   localparam int SEL_W = sel_width(NUM_IN);

   logic              load_en;
   logic              xfer;
   logic [NUM_IN-1:0] grant;
   logic [SEL_W-1:0]  grant_idx;

   assign load_en  = (!out_valid | out_ready) & !rst;
   assign in_ready = grant & {NUM_IN{load_en}};
   assign xfer     = |(in_valid & in_ready);

   generate
      if (MODE == MUX_MODE_RR) begin : g_rr
         rr_arbiter #(
            .NUM_IN    (NUM_IN)
         ) u_arb (
            .clk       (clk),
            .rst       (rst),
            .req       (in_valid),
            .advance   (xfer),
            .grant     (grant),
            .grant_idx (grant_idx)
         );
      end else begin : g_sel
         // Out-of-range selects fall back to channel 0.
         always_comb begin
            grant     = '0;
            grant_idx = '0;
            if (int'(sel) < NUM_IN) begin
               grant_idx = sel;
            end
            if (in_valid[grant_idx]) begin
               grant[grant_idx] = 1'b1;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= in_data[int'(grant_idx)*WIDTH_DATA +: WIDTH_DATA];
         out_src   <= grant_idx;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 The block SHALL have parameter WIDTH_DATA, default 32, which is the data bits per channel.
REQ-002 The block SHALL have parameter NUM_IN, default 4, legal range 2..8, which is the number of input channels.
REQ-003 The block SHALL have parameter MODE, default 0; 0 selects by the sel input, 1 selects by round-robin arbitration.
REQ-004 SEL_W SHALL equal ceil(log2(NUM_IN)), derived and not overridable.
REQ-005 clk  input  1  is the sole clock; all state SHALL update on the rising edge.
REQ-006 rst  input  1  is a synchronous, active-high reset.
REQ-007 in_data  input  NUM_IN*WIDTH_DATA  carries the packed channels, with channel k at bits [k*WIDTH_DATA +: WIDTH_DATA].
REQ-008 in_valid  input  NUM_IN  SHALL indicate that channel k offers data.
REQ-009 in_ready  output  NUM_IN  SHALL indicate that channel k is accepted this cycle.
REQ-010 sel  input  SEL_W  is the channel select in MODE 0 and SHALL be ignored in MODE 1.
REQ-011 out_data  output  WIDTH_DATA  carries the registered selected data.
REQ-012 out_valid  output  1  SHALL indicate that out_data holds an untaken word.
REQ-013 out_ready  input  1  is asserted when the downstream consumer accepts the word.
REQ-014 out_src  output  SEL_W  SHALL give the channel index that out_data came from.

Function
REQ-015 A transfer on channel k SHALL occur when in_valid[k] and in_ready[k] are both high at a clock edge; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-016 The load enable SHALL equal (!out_valid | out_ready) & !rst.
REQ-017 in_ready SHALL be combinational, zero-or-one-hot, and high only on the granted channel while the load enable is high.
REQ-018 In MODE 0, the grant SHALL be channel sel if in_valid[sel] is high, and no grant otherwise.
REQ-019 In MODE 0, an out-of-range sel (sel >= NUM_IN) SHALL be treated as channel 0.
REQ-020 In MODE 1, the grant SHALL go to the first channel with in_valid high, searching upward from the pointer ptr and wrapping from NUM_IN-1 to 0.
REQ-021 In MODE 1, ptr SHALL become (granted index + 1) mod NUM_IN only on an input transfer, and SHALL be unchanged otherwise.
REQ-022 On an input transfer, out_data and out_src SHALL be loaded from the granted channel and out_valid SHALL be set, giving a latency of one cycle from input transfer to out_valid.
REQ-023 Simultaneous output transfer and input transfer in the same cycle SHALL replace the word with no bubble, allowing full throughput of one word per cycle.
REQ-024 An output transfer with no input transfer SHALL clear out_valid.
REQ-025 While out_valid is high and out_ready is low, out_data, out_src, out_valid and ptr SHALL hold stable and in_ready SHALL be all-zero.
REQ-026 A change to in_valid or sel that does not result in a transfer SHALL NOT alter any state.

Reset
REQ-027 While rst is high, in_ready SHALL be all-zero and no transfer SHALL occur.
REQ-028 The cycle after rst is sampled high, out_valid SHALL be 0, out_data SHALL be 0, out_src SHALL be 0, and ptr SHALL be 0.
REQ-029 An assertion of rst while out_valid is high SHALL discard the held word without an output transfer.

Structure
REQ-030 MODE encodings (MUX_MODE_SEL=0, MUX_MODE_RR=1) and the SEL_W width function SHALL reside in the shared package cocoa_mux_pkg.
REQ-031 Grant generation and ptr SHALL form one sub-module, rr_arbiter (parameter NUM_IN, with inputs req, advance and outputs grant, grant_idx), instantiated only when MODE=1.
REQ-032 MODE 0 SHALL use a direct indexed select with no arbiter instance.
REQ-033 The output register SHALL be a single stage, with no internal FIFO.

Verification
REQ-034 MODE 0, NUM_IN=4, sel=2, in_valid=4'b0100, data2=0xDEADBEEF, out_ready=1 -> in_ready=4'b0100, and the next cycle out_data=0xDEADBEEF, out_src=2, out_valid=1.
REQ-035 MODE 1, NUM_IN=4, in_valid=4'b1111 held, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3, with one word every cycle.
REQ-036 MODE 1, in_valid=4'b1010 after ptr=2 -> grant goes to channel 3, then ptr=0, and the next grant goes to channel 1 (wrap check).
REQ-037 Backpressure: out_valid=1, out_ready=0 for 5 cycles with all in_valid high -> in_ready=0 and out_data/out_src remain constant; releasing out_ready accepts the next word in the same cycle.
REQ-038 MODE 0, NUM_IN=6, sel=7, in_valid[0]=1 -> channel 0 is granted and out_src=0.
REQ-039 Pulse rst for one cycle while out_valid=1, out_ready=0, ptr=3 -> the next cycle out_valid=0, out_data=0, out_src=0, ptr=0, and no output transfer is observed.
